// File: rtl/nota_sequenciador_if.sv
// Control, RAM-load and decoder-facing signals of the melody sequencer.
// The master drives the controls; the sequencer is the slave.
interface nota_sequenciador_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          iniciar;
   logic          parar;
   logic          repetir;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          tom;
   logic          notas1;
   logic          notas2;
   logic          notas3;
   logic          nota_valida;
   logic          ocupado;
   logic          fim;
   logic [AW-1:0] indice;

   modport master (
      output iniciar, parar, repetir, wr_en, wr_addr, wr_data,
      input  tom, notas1, notas2, notas3, nota_valida, ocupado, fim, indice
   );

   modport slave (
      input  iniciar, parar, repetir, wr_en, wr_addr, wr_data,
      output tom, notas1, notas2, notas3, nota_valida, ocupado, fim, indice
   );
endinterface

// File: rtl/nota_sequenciador.sv
// Melody sequencer: plays {tom, notas, duracao} entries from a small RAM to the
// note decoder, one note at a time, with a one-cycle gap between notes.
module nota_sequenciador #(
   parameter int DEPTH          = 16,
   parameter int TICKS_PER_BEAT = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   nota_sequenciador_if.slave  bus
);
   localparam int              AW          = $clog2(DEPTH);
   localparam int              TW          = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
   localparam logic [TW-1:0]   TICK_RELOAD = TW'(TICKS_PER_BEAT - 1);
   localparam logic [AW-1:0]   LAST_IDX    = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] indice_q, indice_d;
   logic [3:0]    beat_q, beat_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          tom_q, tom_d;
   logic [2:0]    notas_q, notas_d;
   logic          valid_q, valid_d;
   logic          ocupado_q, ocupado_d;
   logic          fim_q, fim_d;
   logic          end_req;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    entry;

   // NOTE: the melody RAM deliberately has no reset so a loaded tune survives rst_n.
   always_ff @(posedge clk) begin
      if (bus.wr_en && state_q == IDLE) mem_q[bus.wr_addr] <= bus.wr_data;
   end

   assign entry = mem_q[indice_q];

   // NOTE: every variable gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d  = state_q;
      indice_d = indice_q;
      beat_d   = beat_q;
      tick_d   = tick_q;
      tom_d    = tom_q;
      notas_d  = notas_q;
      valid_d  = valid_q;
      fim_d    = 1'b0;
      end_req  = 1'b0;

      case (state_q)
         IDLE: begin
            tom_d   = 1'b0;
            notas_d = '0;
            valid_d = 1'b0;
            if (bus.iniciar) begin
               state_d  = FETCH;
               indice_d = '0;
            end
         end
         FETCH: begin
            valid_d = 1'b0;
            if (entry[3:0] != 4'd0) begin
               tom_d   = entry[7];
               notas_d = entry[6:4];
               valid_d = 1'b1;
               beat_d  = entry[3:0];
               tick_d  = TICK_RELOAD;
               state_d = PLAY;
            end else begin
               end_req = 1'b1;
            end
         end
         PLAY: begin
            if (tick_q == '0) begin
               tick_d = TICK_RELOAD;
               if (beat_q == 4'd1) begin
                  if (indice_q == LAST_IDX) begin
                     end_req = 1'b1;
                  end else begin
                     indice_d = indice_q + 1'b1;
                     valid_d  = 1'b0;
                     state_d  = FETCH;
                  end
               end else begin
                  beat_d = beat_q - 4'd1;
               end
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Entry 0 being the end point means an empty melody, which must never loop.
      if (end_req) begin
         valid_d  = 1'b0;
         indice_d = '0;
         if (bus.repetir && indice_q != '0) begin
            state_d = FETCH;
         end else begin
            state_d = IDLE;
            fim_d   = 1'b1;
            tom_d   = 1'b0;
            notas_d = '0;
         end
      end

      if (bus.parar) begin
         state_d  = IDLE;
         indice_d = '0;
         beat_d   = '0;
         tick_d   = '0;
         tom_d    = 1'b0;
         notas_d  = '0;
         valid_d  = 1'b0;
         fim_d    = 1'b0;
      end

      ocupado_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         indice_q  <= '0;
         beat_q    <= '0;
         tick_q    <= '0;
         tom_q     <= 1'b0;
         notas_q   <= '0;
         valid_q   <= 1'b0;
         ocupado_q <= 1'b0;
         fim_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         indice_q  <= indice_d;
         beat_q    <= beat_d;
         tick_q    <= tick_d;
         tom_q     <= tom_d;
         notas_q   <= notas_d;
         valid_q   <= valid_d;
         ocupado_q <= ocupado_d;
         fim_q     <= fim_d;
      end
   end

   assign bus.tom         = tom_q;
   assign bus.notas1      = notas_q[2];
   assign bus.notas2      = notas_q[1];
   assign bus.notas3      = notas_q[0];
   assign bus.nota_valida = valid_q;
   assign bus.ocupado     = ocupado_q;
   assign bus.fim         = fim_q;
   assign bus.indice      = indice_q;
endmodule

// File: tb/tb_nota_sequenciador.sv
// Bench for nota_sequenciador: an expected per-cycle trace is derived from the
// melody contents and compared with the outputs after every clock edge.
module tb_nota_sequenciador;
   localparam int DEPTH = 16;
   localparam int TICKS = 4;
   localparam int AW    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nota_sequenciador_if #(.DEPTH(DEPTH)) bus ();

   nota_sequenciador #(.DEPTH(DEPTH), .TICKS_PER_BEAT(TICKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          ocupado;
      logic          valid;
      logic          fim;
      logic [3:0]    tom_notas;
      logic [AW-1:0] indice;
   } obs_t;

   typedef struct {
      obs_t o;
      bit   notes_chk;
   } exp_t;

   logic [7:0] model_mem [DEPTH];
   exp_t       exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic exp_t idle_rec(input bit fim);
      exp_t e;
      e.o         = '{ocupado: 1'b0, valid: 1'b0, fim: fim, tom_notas: 4'h0, indice: '0};
      e.notes_chk = 1'b1;
      return e;
   endfunction

   // Walk the melody as a musician would: fetch gap, hold duracao*TICKS, advance.
   task automatic build(input bit rep, input int cap);
      int         idx;
      int         dur;
      bit         done;
      exp_t       e;
      exp_q.delete();
      idx  = 0;
      done = 1'b0;
      while (!done && exp_q.size() < cap) begin
         e.o         = '{ocupado: 1'b1, valid: 1'b0, fim: 1'b0, tom_notas: 4'h0, indice: AW'(idx)};
         e.notes_chk = 1'b0;
         exp_q.push_back(e);
         dur = int'(model_mem[idx][3:0]);
         if (dur != 0) begin
            e.o         = '{ocupado: 1'b1, valid: 1'b1, fim: 1'b0,
                            tom_notas: model_mem[idx][7:4], indice: AW'(idx)};
            e.notes_chk = 1'b1;
            repeat (dur * TICKS) exp_q.push_back(e);
         end
         if (dur == 0 || idx == DEPTH - 1) begin
            if (rep && idx != 0) idx = 0;
            else begin
               exp_q.push_back(idle_rec(1'b1));
               done = 1'b1;
            end
         end else begin
            idx++;
         end
      end
   endtask

   task automatic check_step(input string tag, input exp_t e);
      obs_t a;
      a = '{ocupado: bus.ocupado, valid: bus.nota_valida, fim: bus.fim,
            tom_notas: {bus.tom, bus.notas1, bus.notas2, bus.notas3}, indice: bus.indice};
      if (!e.notes_chk) a.tom_notas = 4'h0;
      check(tag, 32'(a), 32'(e.o));
   endtask

   task automatic write_mem(input int addr, input logic [7:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic play(input string tag, input bit rep, input int max_cyc, input int stop_at,
                       input bit poke, input bit wr0, input logic [7:0] wr0_data);
      bit   stopped;
      exp_t e;
      if (wr0) model_mem[0] = wr0_data;
      build(rep, max_cyc + 1);
      bus.repetir = rep;
      bus.iniciar = 1'b1;
      if (wr0) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = '0;
         bus.wr_data = wr0_data;
      end
      @(posedge clk); #1;
      bus.iniciar = 1'b0;
      bus.wr_en   = 1'b0;
      stopped     = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         if (stopped || c >= exp_q.size()) e = idle_rec(1'b0);
         else e = exp_q[c];
         check_step(tag, e);
         bus.parar = (c == stop_at);
         if (c == stop_at) stopped = 1'b1;
         if (poke && c == 3) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = model_mem[0] ^ 8'hE1;
            bus.iniciar = 1'b1;
         end else begin
            bus.wr_en   = 1'b0;
            bus.iniciar = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.parar   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.iniciar = 1'b0;
   endtask

   initial begin
      bus.iniciar = 1'b0;
      bus.parar   = 1'b0;
      bus.repetir = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check_step("reset", idle_rec(1'b0));
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) write_mem(i, 8'h00);
      write_mem(1, 8'b1_101_0001);
      write_mem(2, 8'h00);

      // Two-note melody; entry 0 written on the same edge as iniciar.
      play("two_notes", 1'b0, 20, -1, 1'b0, 1'b1, 8'b0_001_0010);
      play("loop_stop", 1'b1, 60, 40, 1'b0, 1'b0, 8'h00);

      // Writes and iniciar while busy must change nothing, shown by the replay.
      play("busy_poke", 1'b0, 20, -1, 1'b1, 1'b0, 8'h00);
      play("replay", 1'b0, 20, -1, 1'b0, 1'b0, 8'h00);

      play("pre_reset", 1'b1, 6, -1, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_step("reset_mid1", idle_rec(1'b0));
      @(posedge clk); #1;
      check_step("reset_mid2", idle_rec(1'b0));
      rst_n = 1'b1;
      play("ram_kept", 1'b0, 20, -1, 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < DEPTH; i++) write_mem(i, {4'(i), 4'd1});
      play("full_16", 1'b0, 85, -1, 1'b0, 1'b0, 8'h00);

      write_mem(0, 8'hF0);
      play("empty_loop", 1'b1, 5, -1, 1'b0, 1'b0, 8'h00);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEPTH; i++)
            write_mem(i, {4'($urandom), 4'($urandom_range(0, 3))});
         play("random", 1'($urandom), 150, $urandom_range(20, 140), 1'b0, 1'b0, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
